button_led_ctrl: RTL
====================

Name: button_led_ctrl

Overview:
- Parametrised N-channel push-button front end driving N LEDs; successor to the fixed 4-button LED decoder.
- Adds per-channel synchronisation, counter-based debounce and rising-edge pulses.
- Two runtime modes: follow (one-hot/chord decode with blink) and toggle (per-channel latch).
- Sits between board buttons and LED pins; also exports clean button state and edge pulses to other logic.

Parameters:
- N_CH, 4, number of button/LED channels (2..16).
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles before a debounced state change (20 ms at 50 MHz).
- BLINK_HALF_CYCLES, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz).
- CHORD_MASK, 4'b1001 (N_CH bits), button combination that triggers blink/clear.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- btn  input  N_CH  raw asynchronous button levels, bit i = channel i.
- mode  input  1  0 = follow, 1 = toggle; must be treated as synchronous (sample once per clk).
- led  output  N_CH  registered LED drive, 1 = on.
- btn_state  output  N_CH  debounced button levels.
- btn_rise  output  N_CH  one-clk pulse on debounced 0->1 per channel.

Behaviour:
- Reset (reset=0, async): sync FFs, stable state, debounce counters, latches, blink counter/phase, FSM all 0; led=0, btn_state=0, btn_rise=0.
- Sync: 2-FF synchroniser per channel.
- Debounce, per channel:
  - counter clears whenever sync value == stable value;
  - otherwise it increments;
  - when it reaches DEBOUNCE_CYCLES-1 the stable bit flips and the counter clears.
  - Glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Counter width = clog2(DEBOUNCE_CYCLES).
- btn_state = stable vector. btn_rise[i] = stable[i] & ~stable_d[i], high exactly one cycle.
- Latency: raw edge -> btn_state change = 2 (sync) + DEBOUNCE_CYCLES cycles; btn_state -> led = 1 cycle.
- Follow mode FSM, evaluated on btn_state:
  - IDLE: led=0.
  - SINGLE: entered when btn_state is one-hot; led=btn_state.
  - CHORD: entered when btn_state==CHORD_MASK; led=CHORD_MASK while phase=0, led=0 while phase=1.
  - Any other pattern (zero, multi-bit non-chord) -> IDLE.
  - Transitions take effect the cycle after btn_state changes.
- Blink timer: free-running counter of BLINK_HALF_CYCLES; toggles phase at terminal count.
  - On every entry to CHORD, counter and phase clear, so LEDs are on for the first full half-period.
- Toggle mode:
  - btn_rise[i] toggles latch[i]; simultaneous rises toggle each affected bit independently.
  - A rise event that makes btn_state==CHORD_MASK clears all latches instead of toggling.
  - led=latch.
- Mode change (mode differs from previous sampled value): latches clear, FSM -> IDLE, led=0 next cycle; debounce state is preserved.
- Reset mid-debounce or mid-blink: everything returns to reset values immediately; no pending edge is reported after release.
- CHORD_MASK with a single bit set: chord takes priority over SINGLE.

Optional Feature:
- Macro BTN_ACTIVE_LOW_EN.
- Defined: btn is inverted before the synchroniser (pressed = 0 on the pin). Reset value of the sync FFs stays 0 in the post-inversion domain.
- Undefined: btn is active-high as given.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=8, N_CH=4, CHORD_MASK=4'b1001):
- Reset, then btn=4'b0010 held 10 cycles, mode=0 -> btn_state=0010 after 2+4 cycles; btn_rise[1] one pulse; led=0010 one cycle later. Release -> led=0000.
- btn[0] glitches high 3 cycles then low, mode=0 -> btn_state, btn_rise and led stay 0000.
- btn=4'b1001 held 40 cycles, mode=0 -> led alternates 1001 for 8 cycles / 0000 for 8 cycles, starting with 1001.
- mode=1, press/release btn[2] twice (each press held ≥6 cycles) -> led 0100 after first press, 0000 after second. Then press btn[0]+btn[3] together -> all latches clear, led=0000.
- mode=1 with latch=0101, switch mode to 0 -> led=0000 next cycle. Assert reset mid-blink -> led=0000 immediately (async).
- Compile with BTN_ACTIVE_LOW_EN, drive btn=4'b1110 -> btn_state=0001, led=0001 in follow mode.

Source files
------------

// File: rtl/button_led_ctrl.sv
// N-channel button front end: sync, debounce, rise pulses, follow/toggle LED drive.
// Define BTN_ACTIVE_LOW_EN for buttons that pull the pin low when pressed.
module button_led_ctrl #(
  parameter int unsigned N_CH              = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned BLINK_HALF_CYCLES = 25000000,
  parameter logic [N_CH-1:0] CHORD_MASK    = N_CH'(4'b1001)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn,
  input  logic            mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_rise
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    CHORD
  } state_e;

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] stable_q, stable_d, stable_dly_q;
  logic [DW-1:0]   cnt_q [N_CH];
  logic [DW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] latch_q, latch_d;
  logic [N_CH-1:0] led_q, led_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            phase_q, phase_d;
  logic            mode_q;
  state_e          state_q, state_d;

  logic mode_chg, toggle_en, follow_en;
  logic is_chord, one_hot, single_nc;

`ifdef BTN_ACTIVE_LOW_EN
  assign btn_in = ~btn;
`else
  assign btn_in = btn;
`endif

  assign btn_state = stable_q;
  assign btn_rise  = stable_q & ~stable_dly_q;
  assign led       = led_q;

  assign mode_chg  = mode ^ mode_q;
  assign toggle_en = mode & ~mode_chg;
  assign follow_en = ~mode & ~mode_chg;

  assign is_chord  = (stable_q == CHORD_MASK);
  assign one_hot   = (stable_q != '0) &&
                     ((stable_q & (stable_q - 1'b1)) == '0);
  assign single_nc = one_hot & ~is_chord;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) stable_d[i] = ~stable_q[i];
        else cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    latch_d = latch_q;
    led_d   = '0;
    if (bcnt_q == BL_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + BW'(1);
      phase_d = phase_q;
    end
    unique case (1'b1)
      mode_chg: begin
        latch_d = '0;
      end
      toggle_en: begin
        if ((|btn_rise) && is_chord) latch_d = '0;
        else latch_d = latch_q ^ btn_rise;
        led_d = latch_d;
      end
      follow_en: begin
        unique case (1'b1)
          is_chord:  state_d = CHORD;
          single_nc: state_d = SINGLE;
          default:   state_d = IDLE;
        endcase
        // restart the blink so a fresh chord always opens with LEDs on
        if (state_d == CHORD && state_q != CHORD) begin
          bcnt_d  = '0;
          phase_d = 1'b0;
        end
        case (state_d)
          CHORD:   led_d = phase_d ? '0 : CHORD_MASK;
          SINGLE:  led_d = stable_q;
          default: led_d = '0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= '0;
      latch_q      <= '0;
      led_q        <= '0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
      mode_q       <= 1'b0;
      state_q      <= IDLE;
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= cnt_d[i];
      latch_q      <= latch_d;
      led_q        <= led_d;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
      mode_q       <= mode;
      state_q      <= state_d;
    end
  end

endmodule
